// File: rtl/sprite_line_scanner.sv
// Sprite table scanner: walks every 4-byte entry through the table RAM read port
// and streams the sprites that cover the requested scanline to the line renderer.
module sprite_line_scanner #(
  parameter int ADDR_WIDTH = 6,
  parameter int SPRITE_H   = 8,
  parameter int MAX_HITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            line,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_q,
  output logic                  spr_valid,
  input  logic                  spr_ready,
  output logic [7:0]            spr_x,
  output logic [7:0]            spr_tile,
  output logic [7:0]            spr_attr,
  output logic [7:0]            spr_row,
  output logic [ADDR_WIDTH-3:0] spr_index,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int IW      = ADDR_WIDTH - 2;
  localparam int NUM_SPR = 2 ** IW;
  localparam int CW      = $clog2(NUM_SPR + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPR - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_HITS);
  localparam logic [8:0]    HEIGHT   = 9'(SPRITE_H);

  typedef enum logic [2:0] {IDLE, RD_Y, CHK_Y, GET_X, GET_T, GET_A, OUT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_inc;
  logic [CW-1:0]   hit_cnt;
  logic [7:0]      line_q;
  logic [7:0]      row;
  logic            hit;

  assign idx_inc = idx + IW'(1);
  assign row     = line_q - mem_q;
  assign hit     = (mem_q != 8'hFF) && ({1'b0, row} < HEIGHT);
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

  // OUT already presents the next entry's Y byte, so after a transfer the scan
  // resumes directly in CHK_Y and a hit costs 5 cycles instead of 6.
  always_comb begin
    mem_addr = '0;
    unique case (state)
      RD_Y:    mem_addr = {idx, 2'd0};
      CHK_Y:   mem_addr = {idx, 2'd1};
      GET_X:   mem_addr = {idx, 2'd2};
      GET_T:   mem_addr = {idx, 2'd3};
      OUT:     mem_addr = {idx_inc, 2'd0};
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      hit_cnt   <= '0;
      line_q    <= '0;
      spr_valid <= 1'b0;
      spr_x     <= '0;
      spr_tile  <= '0;
      spr_attr  <= '0;
      spr_row   <= '0;
      spr_index <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            line_q   <= line;
            idx      <= '0;
            hit_cnt  <= '0;
            overflow <= 1'b0;
            state    <= RD_Y;
          end
        end
        RD_Y: state <= CHK_Y;
        CHK_Y: begin
          if (hit) begin
            if (hit_cnt == MAX_CNT) begin
              overflow <= 1'b1;
              state    <= DONE;
            end else begin
              spr_row <= row;
              state   <= GET_X;
            end
          end else if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx_inc;
            state <= RD_Y;
          end
        end
        GET_X: begin
          spr_x <= mem_q;
          state <= GET_T;
        end
        GET_T: begin
          spr_tile <= mem_q;
          state    <= GET_A;
        end
        GET_A: begin
          spr_attr  <= mem_q;
          spr_index <= idx;
          spr_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (spr_ready) begin
            spr_valid <= 1'b0;
            hit_cnt   <= hit_cnt + CW'(1);
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx_inc;
              state <= CHK_Y;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Scoreboard bench for sprite_line_scanner: directed tables, expected hits queued
// at stimulus time and popped by a monitor on every accepted transfer.
module tb_sprite_line_scanner;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] row;
    logic [3:0] index;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] line = 8'd0;
  logic [5:0] mem_addr;
  logic [7:0] mem_q;
  logic       spr_valid;
  logic       spr_ready = 1'b1;
  logic [7:0] spr_x, spr_tile, spr_attr, spr_row;
  logic [3:0] spr_index;
  logic       busy, done, overflow;

  logic [7:0] ram [64];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= ram[mem_addr];

  sprite_line_scanner #(.ADDR_WIDTH(6), .SPRITE_H(8), .MAX_HITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .line(line),
    .mem_addr(mem_addr), .mem_q(mem_q),
    .spr_valid(spr_valid), .spr_ready(spr_ready),
    .spr_x(spr_x), .spr_tile(spr_tile), .spr_attr(spr_attr),
    .spr_row(spr_row), .spr_index(spr_index),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Monitor: every accepted transfer is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && spr_valid && spr_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got idx=%0d x=%0d, none expected", spr_index, spr_x);
      end else begin
        e = exp_q.pop_front();
        if ({spr_x, spr_tile, spr_attr, spr_row, spr_index} !== e) begin
          errors++;
          $display("FAIL transfer: got x=%0d tile=%0d attr=%h row=%0d idx=%0d, want x=%0d tile=%0d attr=%h row=%0d idx=%0d",
                   spr_x, spr_tile, spr_attr, spr_row, spr_index, e.x, e.tile, e.attr, e.row, e.index);
        end else begin
          $display("transfer idx=%0d x=%0d tile=%0d attr=%h row=%0d ok", spr_index, spr_x, spr_tile, spr_attr, spr_row);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) ram[i] = ((i % 4) == 0) ? 8'hFF : 8'h00;
  endtask

  task automatic set_entry(input int i, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] t, input logic [7:0] a);
    ram[i*4] = y; ram[i*4+1] = x; ram[i*4+2] = t; ram[i*4+3] = a;
  endtask

  task automatic expect_hit(input logic [7:0] x, input logic [7:0] t, input logic [7:0] a,
                            input logic [7:0] r, input logic [3:0] i);
    exp_q.push_back({x, t, a, r, i});
  endtask

  // One scan: start is sampled at edge E0; cycle c is the c-th negedge after E0.
  task automatic scan(input string name, input logic [7:0] ln, input int exp_done,
                      input logic exp_ovf, input bit stall, input int poke);
    int  done_at = 0;
    bit  busy_ok = 1'b1;
    spr_ready = !stall;
    @(posedge clk); #1 start = 1'b1; line = ln;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin
        for (int c = 1; c <= 300 && done_at == 0; c++) begin
          @(negedge clk);
          if (done) begin
            done_at = c;
            if (busy) busy_ok = 1'b0;
          end else if (busy !== 1'b1) begin
            busy_ok = 1'b0;
          end
          if (c == poke) begin start = 1'b1; line = 8'd27; end
          else start = 1'b0;
        end
      end
      begin
        if (stall) begin
          int w = 0;
          while (!spr_valid && w < 300) begin @(negedge clk); w++; end
          for (int i = 0; i < 10; i++) begin
            checks++;
            if (!spr_valid || exp_q.size() == 0 ||
                {spr_x, spr_tile, spr_attr, spr_row, spr_index} !== exp_q[0]) begin
              errors++;
              $display("FAIL %s_stall: cycle %0d valid=%0b x=%0d tile=%0d attr=%h row=%0d idx=%0d",
                       name, i, spr_valid, spr_x, spr_tile, spr_attr, spr_row, spr_index);
            end
            if (i < 9) @(negedge clk);
          end
          @(posedge clk); #1 spr_ready = 1'b1;
        end
      end
    join
    start = 1'b0;
    check({name, "_done_cycle"}, done_at, exp_done);
    check({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({name, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    $display("scan %s line=%0d done_at=%0d overflow=%0b", name, ln, done_at, overflow);
    spr_ready = 1'b1;
  endtask

  initial begin
    bit quiet = 1'b1;
    clear_table();
    repeat (3) @(negedge clk);
    check("reset_outputs", {mem_addr, spr_valid, spr_x, spr_tile, spr_attr, spr_row, spr_index, busy, done, overflow}, 0);
    @(posedge clk); #1 reset = 1'b0;

    scan("all_miss", 8'd10, 33, 1'b0, 1'b0, 0);

    set_entry(3, 8'd20, 8'd50, 8'd7, 8'h81);
    expect_hit(8'd50, 8'd7, 8'h81, 8'd5, 4'd3);
    scan("single_hit", 8'd25, 36, 1'b0, 1'b0, 5);

    clear_table();
    set_entry(0, 8'd20, 8'd11, 8'd22, 8'd33);
    expect_hit(8'd11, 8'd22, 8'd33, 8'd0, 4'd0);
    scan("row_first", 8'd20, 36, 1'b0, 1'b0, 0);
    expect_hit(8'd11, 8'd22, 8'd33, 8'd7, 4'd0);
    scan("row_last", 8'd27, 36, 1'b0, 1'b0, 0);
    scan("below", 8'd28, 33, 1'b0, 1'b0, 0);
    scan("above", 8'd19, 33, 1'b0, 1'b0, 0);
    set_entry(0, 8'hFC, 8'd11, 8'd22, 8'd33);
    expect_hit(8'd11, 8'd22, 8'd33, 8'd6, 4'd0);
    scan("wrap", 8'd2, 36, 1'b0, 1'b0, 0);

    clear_table();
    foreach (ram[i]) if (0) ram[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      int id;
      id = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : (k == 3) ? 8 : (k == 4) ? 9 : 12;
      set_entry(id, 8'd40, 8'(id * 10), 8'(id + 100), 8'(id + 8'h40));
    end
    expect_hit(8'd10, 8'd101, 8'h41, 8'd0, 4'd1);
    expect_hit(8'd20, 8'd102, 8'h42, 8'd0, 4'd2);
    expect_hit(8'd50, 8'd105, 8'h45, 8'd0, 4'd5);
    expect_hit(8'd80, 8'd108, 8'h48, 8'd0, 4'd8);
    scan("overflow", 8'd40, 33, 1'b1, 1'b0, 0);

    set_entry(9, 8'hFF, 8'd0, 8'd0, 8'd0);
    set_entry(12, 8'hFF, 8'd0, 8'd0, 8'd0);
    expect_hit(8'd10, 8'd101, 8'h41, 8'd0, 4'd1);
    expect_hit(8'd20, 8'd102, 8'h42, 8'd0, 4'd2);
    expect_hit(8'd50, 8'd105, 8'h45, 8'd0, 4'd5);
    expect_hit(8'd80, 8'd108, 8'h48, 8'd0, 4'd8);
    scan("ovf_clear", 8'd40, 45, 1'b0, 1'b0, 0);

    clear_table();
    set_entry(3, 8'd20, 8'd50, 8'd7, 8'h81);
    expect_hit(8'd50, 8'd7, 8'h81, 8'd5, 4'd3);
    scan("backpressure", 8'd25, 46, 1'b0, 1'b1, 0);

    // Abort mid-scan: reset lands while entry 3 is in GET_T (cycle 10).
    @(posedge clk); #1 start = 1'b1; line = 8'd25;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_abort_state", {busy, spr_x, spr_row, 2'b00, mem_addr}, {1'b1, 8'd50, 8'd5, 2'b00, 6'd15});
    #2 reset = 1'b1;
    #1 check("abort_outputs", {mem_addr, spr_valid, spr_x, spr_tile, spr_attr, spr_row, spr_index, busy, done, overflow}, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy || spr_valid) quiet = 1'b0;
    end
    check("abort_quiet", {31'd0, quiet}, 32'd1);
    $display("abort scan quiet=%0b", quiet);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
